// File: rtl/mini_intc.sv
// Pulse-driven interrupt controller: per-source edge capture and pending bits,
// mask, fixed lowest-index priority and an irq/ack handshake to the host.
// Optional sticky overrun flags are built when MINI_INTC_OVERRUN_EN is defined.

module mini_intc_src (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_irq,
  input  logic i_clr,
`ifdef MINI_INTC_OVERRUN_EN
  input  logic i_ovr_clr,
  output logic o_ovr,
`endif
  output logic o_pend
);
  logic r_prev, r_pend, w_edge;

  assign w_edge = i_irq & ~r_prev;
  assign o_pend = r_pend;

  // a same-cycle edge beats the ack clear so no request is lost
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_prev <= 1'b0;
      r_pend <= 1'b0;
    end else begin
      r_prev <= i_irq;
      r_pend <= w_edge | (r_pend & ~i_clr);
    end
  end

`ifdef MINI_INTC_OVERRUN_EN
  logic r_ovr;
  assign o_ovr = r_ovr;
  always_ff @(posedge i_clk) begin
    if (i_reset) r_ovr <= 1'b0;
    else         r_ovr <= (w_edge & r_pend) | (r_ovr & ~i_ovr_clr);
  end
`endif
endmodule

module mini_intc #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = 3
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NUM_SRC-1:0] i_irq_in,
  input  logic               i_mask_we,
  input  logic [NUM_SRC-1:0] i_mask_wdata,
  input  logic               i_ack,
`ifdef MINI_INTC_OVERRUN_EN
  input  logic               i_overrun_clr,
  output logic [NUM_SRC-1:0] o_overrun,
`endif
  output logic               o_irq_out,
  output logic [ID_W-1:0]    o_irq_id,
  output logic [NUM_SRC-1:0] o_pending,
  output logic [NUM_SRC-1:0] o_mask
);
  typedef enum logic [1:0] {IDLE, ASSERT, GAP} state_t;

  state_t             r_state, w_state_nxt;
  logic [ID_W-1:0]    r_id, w_id_nxt, w_sel;
  logic [NUM_SRC-1:0] r_mask, w_pend, w_elig, w_clr;
  logic               w_take;

  assign w_take = (r_state == ASSERT) & i_ack;
  assign w_elig = w_pend & ~r_mask;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign w_clr[g] = w_take & (r_id == ID_W'(g));
    mini_intc_src u_src (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_irq    (i_irq_in[g]),
      .i_clr    (w_clr[g]),
`ifdef MINI_INTC_OVERRUN_EN
      .i_ovr_clr(i_overrun_clr),
      .o_ovr    (o_overrun[g]),
`endif
      .o_pend   (w_pend[g])
    );
  end

  // scan high to low so the lowest eligible index is the one left in w_sel
  always_comb begin
    w_sel = '0;
    for (int i = NUM_SRC-1; i >= 0; i--)
      if (w_elig[i]) w_sel = ID_W'(i);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_id_nxt    = r_id;
    unique case (r_state)
      IDLE:    if (|w_elig) begin
                 w_state_nxt = ASSERT;
                 w_id_nxt    = w_sel;
               end
      ASSERT:  if (i_ack) w_state_nxt = GAP;
      GAP:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_id    <= '0;
      r_mask  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_id    <= w_id_nxt;
      if (i_mask_we) r_mask <= i_mask_wdata;
    end
  end

  assign o_irq_out = (r_state == ASSERT);
  assign o_irq_id  = r_id;
  assign o_pending = w_pend;
  assign o_mask    = r_mask;
endmodule

// File: tb/tb_mini_intc.sv
// Directed bench for mini_intc: inputs change 1 time unit after a rising edge,
// outputs are checked just before the next input change.
`timescale 1ns/1ps
module tb_mini_intc;
  logic       clk = 1'b0;
  logic       reset, mask_we, ack;
  logic [3:0] irq_in, mask_wdata;
  logic       irq_out;
  logic [2:0] irq_id;
  logic [3:0] pending, mask;
`ifdef MINI_INTC_OVERRUN_EN
  logic       overrun_clr;
  logic [3:0] overrun;
`endif
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mini_intc #(.NUM_SRC(4), .ID_W(3)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_irq_in     (irq_in),
    .i_mask_we    (mask_we),
    .i_mask_wdata (mask_wdata),
    .i_ack        (ack),
`ifdef MINI_INTC_OVERRUN_EN
    .i_overrun_clr(overrun_clr),
    .o_overrun    (overrun),
`endif
    .o_irq_out    (irq_out),
    .o_irq_id     (irq_id),
    .o_pending    (pending),
    .o_mask       (mask)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; mask_we = 1'b0; ack = 1'b0; irq_in = '0; mask_wdata = '0;
`ifdef MINI_INTC_OVERRUN_EN
    overrun_clr = 1'b0;
`endif
    tick(); tick();
    reset = 1'b0;
    chk("rst_irq_out", 32'(irq_out), 0);
    chk("rst_irq_id",  32'(irq_id),  0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_mask",    32'(mask),    0);
`ifdef MINI_INTC_OVERRUN_EN
    chk("rst_overrun", 32'(overrun), 0);
`endif
    tick(); tick();

    // single pulse on source 2
    irq_in = 4'b0100; tick(); irq_in = '0;
    chk("t1_pend",     32'(pending), 32'h4);
    chk("t1_out_lat0", 32'(irq_out), 0);
    tick();
    chk("t1_out", 32'(irq_out), 1);
    chk("t1_id",  32'(irq_id),  2);
    tick(); tick();
    chk("t1_hold", 32'(irq_out), 1);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("t1_ack_out",  32'(irq_out), 0);
    chk("t1_ack_pend", 32'(pending), 0);
    tick(); tick();

    // simultaneous 3 and 1: priority then back-to-back with one gap cycle
    irq_in = 4'b1010; tick(); irq_in = '0;
    chk("t2_pend", 32'(pending), 32'hA);
    tick();
    chk("t2_out_a", 32'(irq_out), 1);
    chk("t2_id_a",  32'(irq_id),  1);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("t2_gap_out",  32'(irq_out), 0);
    chk("t2_gap_pend", 32'(pending), 32'h8);
    tick();
    chk("t2_idle_out", 32'(irq_out), 0);
    tick();
    chk("t2_out_b", 32'(irq_out), 1);
    chk("t2_id_b",  32'(irq_id),  3);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("t2_end_pend", 32'(pending), 0);
    chk("t2_end_out",  32'(irq_out), 0);
    tick(); tick();

    // masked source retained but not presented until unmasked
    mask_we = 1'b1; mask_wdata = 4'b0001; tick(); mask_we = 1'b0;
    chk("t3_mask", 32'(mask), 1);
    irq_in = 4'b0001; tick(); irq_in = '0;
    chk("t3_pend", 32'(pending), 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t3_masked_out", 32'(irq_out), 0);
    end
    mask_we = 1'b1; mask_wdata = 4'b0000; tick(); mask_we = 1'b0;
    chk("t3_wr_out", 32'(irq_out), 0);
    tick();
    chk("t3_out", 32'(irq_out), 1);
    chk("t3_id",  32'(irq_id),  0);
    // a new higher-index request while asserted must not disturb the id
    irq_in = 4'b0100; tick(); irq_in = '0;
    chk("t3_stable_id", 32'(irq_id), 0);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("t3_pend_after", 32'(pending), 32'h4);
    tick(); tick();
    chk("t3_id_next", 32'(irq_id), 2);
    ack = 1'b1; tick(); ack = 1'b0;
    tick(); tick();

    // level held 5 cycles is one request; ack while still high clears it
    irq_in = 4'b0010;
    tick();
    chk("t4_pend", 32'(pending), 32'h2);
    tick();
    chk("t4_out", 32'(irq_out), 1);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("t4_ack_pend", 32'(pending), 0);
    tick(); tick();
    irq_in = '0; tick();
    chk("t4_single_pend", 32'(pending), 0);
    chk("t4_single_out",  32'(irq_out), 0);
`ifdef MINI_INTC_OVERRUN_EN
    chk("t4_no_ovr", 32'(overrun), 0);
`endif

    // ack coincident with a new edge: set wins, source re-presented
    irq_in = 4'b0010; tick(); irq_in = '0;
    tick();
    chk("t4b_out", 32'(irq_out), 1);
    ack = 1'b1; irq_in = 4'b0010; tick(); ack = 1'b0; irq_in = '0;
    chk("t4b_setwins", 32'(pending), 32'h2);
    chk("t4b_gap",     32'(irq_out), 0);
`ifdef MINI_INTC_OVERRUN_EN
    chk("t4b_ovr", 32'(overrun), 32'h2);
`endif
    tick(); tick();
    chk("t4b_reout", 32'(irq_out), 1);
    chk("t4b_reid",  32'(irq_id),  1);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("t4b_clear", 32'(pending), 0);
`ifdef MINI_INTC_OVERRUN_EN
    chk("t4b_ovr_sticky", 32'(overrun), 32'h2);
    overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
    chk("t4b_ovr_clr", 32'(overrun), 0);
`endif
    tick(); tick();

    // reset in the middle of an assertion
    irq_in = 4'b1010; tick(); irq_in = '0;
    tick();
    mask_we = 1'b1; mask_wdata = 4'b0010; tick(); mask_we = 1'b0;
    chk("t5_out_held", 32'(irq_out), 1);
    chk("t5_id_held",  32'(irq_id),  1);
    chk("t5_pend",     32'(pending), 32'hA);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t5_rst_out",  32'(irq_out), 0);
    chk("t5_rst_pend", 32'(pending), 0);
    chk("t5_rst_mask", 32'(mask),    0);
    chk("t5_rst_id",   32'(irq_id),  0);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("t5_ack_pend", 32'(pending), 0);
    chk("t5_ack_out",  32'(irq_out), 0);
    tick();
    chk("t5_idle_out", 32'(irq_out), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
